// File: rtl/conv_pe_array.sv
// conv_pe_array: NUM_CH parallel signed 8-bit MAC channels sharing one pixel
// stream. Each channel holds its own kernel (loaded once per job), accumulates
// a kern_len-beat dot product per output, then requantises (arithmetic shift,
// optional ReLU, saturate). All channel results go out as one packed OFM write.
//
// Ports:
//   clk, rst          clock (rising edge), async active-low reset
//   start             job start, sampled in IDLE only
//   kern_len          kernel words per output (1..MAX_K), latched at start
//   out_count         outputs per job (>=1), latched at start
//   shift, relu_en    requantisation config, latched at start
//   k_valid/k_ready   kernel word handshake, k_data packs one word per channel
//   pix_valid/ready   shared pixel word handshake
//   ofm_wren/ready    OFM write handshake; ofm_addr, ofm_data stable while stalled
//   busy              high outside IDLE
//   done              one-cycle pulse at job completion
module conv_pe_array #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned LANES  = 4,
  parameter int unsigned MAX_K  = 32,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned OUT_W  = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(MAX_K+1)-1:0]   kern_len,
  input  logic [ADDR_W:0]              out_count,
  input  logic [4:0]                   shift,
  input  logic                         relu_en,
  input  logic                         k_valid,
  input  logic [NUM_CH*LANES*8-1:0]    k_data,
  output logic                         k_ready,
  input  logic                         pix_valid,
  input  logic [LANES*8-1:0]           pix_data,
  output logic                         pix_ready,
  output logic                         ofm_wren,
  input  logic                         ofm_ready,
  output logic [ADDR_W-1:0]            ofm_addr,
  output logic [NUM_CH*OUT_W-1:0]      ofm_data,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned KL_W   = $clog2(MAX_K + 1);
  localparam int unsigned IDX_W  = (MAX_K > 1) ? $clog2(MAX_K) : 1;
  localparam int unsigned WORD_W = LANES * 8;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, DONE} state_t;

  state_t state, state_n;

  logic [KL_W-1:0]   beat, kl_q;
  logic [ADDR_W:0]   outidx, oc_q;
  logic [4:0]        shift_q;
  logic              relu_q;
  logic [WORD_W-1:0] kmem [NUM_CH][MAX_K];
  logic signed [ACC_W-1:0] acc     [NUM_CH];
  logic signed [ACC_W-1:0] acc_nxt [NUM_CH];
  logic [NUM_CH*OUT_W-1:0] req;

  logic signed [7:0]       pa, ka;
  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] rq;

  logic [IDX_W-1:0] bidx;
  logic cfg_ok, k_fire, p_fire, w_fire, beat_last, out_last;

  assign bidx      = beat[IDX_W-1:0];
  assign cfg_ok    = start && (kern_len != '0) && (kern_len <= KL_W'(MAX_K)) &&
                     (out_count != '0);
  assign k_fire    = k_valid && k_ready;
  assign p_fire    = pix_valid && pix_ready;
  assign w_fire    = ofm_wren && ofm_ready;
  assign beat_last = (beat == kl_q - KL_W'(1));
  assign out_last  = ((outidx + (ADDR_W+1)'(1)) == oc_q);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cfg_ok) state_n = LOAD;
      LOAD:    if (k_fire && beat_last) state_n = MAC;
      MAC:     if (p_fire && beat_last) state_n = WRITE;
      WRITE:   if (w_fire) state_n = out_last ? DONE : MAC;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Per-channel dot product of the current pixel with kernel word `beat`,
  // added to the running sum, then requantised into the packed output word
  always_comb begin
    pa   = '0;
    ka   = '0;
    prod = '0;
    rq   = '0;
    req  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      acc_nxt[c] = acc[c];
      for (int i = 0; i < LANES; i++) begin
        pa   = pix_data[i*8 +: 8];
        ka   = kmem[c][bidx][i*8 +: 8];
        prod = pa * ka;
        acc_nxt[c] = acc_nxt[c] + {{(ACC_W-16){prod[15]}}, prod};
      end
      rq = acc_nxt[c] >>> shift_q;
      if (relu_q && rq[ACC_W-1]) rq = '0;
      if (rq > SAT_HI)      req[c*OUT_W +: OUT_W] = SAT_HI[OUT_W-1:0];
      else if (rq < SAT_LO) req[c*OUT_W +: OUT_W] = SAT_LO[OUT_W-1:0];
      else                  req[c*OUT_W +: OUT_W] = rq[OUT_W-1:0];
    end
  end

  // Datapath, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_ready   <= 1'b0;
      pix_ready <= 1'b0;
      ofm_wren  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ofm_addr  <= '0;
      ofm_data  <= '0;
      beat      <= '0;
      outidx    <= '0;
      kl_q      <= '0;
      oc_q      <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c] <= '0;
        for (int k = 0; k < MAX_K; k++) kmem[c][k] <= '0;
      end
    end else begin
      // Handshake/status outputs follow the state being entered
      k_ready   <= (state_n == LOAD);
      pix_ready <= (state_n == MAC);
      ofm_wren  <= (state_n == WRITE);
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      case (state)
        IDLE: if (cfg_ok) begin
          kl_q    <= kern_len;
          oc_q    <= out_count;
          shift_q <= shift;
          relu_q  <= relu_en;
          beat    <= '0;
          outidx  <= '0;
        end
        LOAD: if (k_fire) begin
          for (int c = 0; c < NUM_CH; c++) kmem[c][bidx] <= k_data[c*WORD_W +: WORD_W];
          if (beat_last) begin
            beat <= '0;
            for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
          end else begin
            beat <= beat + KL_W'(1);
          end
        end
        MAC: if (p_fire) begin
          for (int c = 0; c < NUM_CH; c++) acc[c] <= acc_nxt[c];
          if (beat_last) begin
            beat     <= '0;
            ofm_data <= req;
            ofm_addr <= outidx[ADDR_W-1:0];
          end else begin
            beat <= beat + KL_W'(1);
          end
        end
        WRITE: if (w_fire) begin
          outidx <= outidx + (ADDR_W+1)'(1);
          if (!out_last) for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
